// File: rtl/mmio_bus_arbiter_if.sv
// Bus bundle between the two MMIO masters, the arbiter and the MMIO block.
// slave = arbiter view, master = requester/MMIO-model view.
interface mmio_bus_arbiter_if;
   logic        m0_req, m0_wen, m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_addr;
   logic [63:0] m0_wdata, m0_rdata;
   logic [7:0]  m0_be_n;
   logic        m1_req, m1_wen, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_addr;
   logic [63:0] m1_wdata, m1_rdata;
   logic [7:0]  m1_be_n;
   logic [31:0] ext_addr;
   logic [63:0] ext_data;
   logic [7:0]  ext_ram_be_n;
   logic        ext_ram_wen;
   logic [63:0] mmio_read_data;
   logic        mmio_en_reg;

   modport slave (
      input  m0_req, m0_wen, m0_addr, m0_wdata, m0_be_n,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_wen, m1_addr, m1_wdata, m1_be_n,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output ext_addr, ext_data, ext_ram_be_n, ext_ram_wen,
      input  mmio_read_data, mmio_en_reg
   );

   modport master (
      output m0_req, m0_wen, m0_addr, m0_wdata, m0_be_n,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_wen, m1_addr, m1_wdata, m1_be_n,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  ext_addr, ext_data, ext_ram_be_n, ext_ram_wen,
      output mmio_read_data, mmio_en_reg
   );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin share of the single MMIO port between m0 (LSU) and m1 (DMA/debug), one transaction in flight.
// Latency: gnt T, ext bus T+1, response sampled T+2, rvalid T+3; unanswered reads error at T+2+TIMEOUT.
// Backpressure: gnt only from IDLE, requesters hold req until gnt; MMIO_ARB_STATS_EN adds saturating counters.
module mmio_bus_arbiter #(
   parameter int TIMEOUT = 16
`ifdef MMIO_ARB_STATS_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic clk,
   input  logic rst,
   mmio_bus_arbiter_if.slave io_bus
`ifdef MMIO_ARB_STATS_EN
   , output logic [CNT_W-1:0] stat_gnt0,
   output logic [CNT_W-1:0] stat_gnt1,
   output logic [CNT_W-1:0] stat_timeout
`endif
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state, w_next;
   logic          r_rr_ptr, r_owner, r_wen, r_err;
   logic [CW-1:0] r_cnt;
   logic [63:0]   r_rdata;
   logic [31:0]   r_ext_addr;
   logic [63:0]   r_ext_data;
   logic [7:0]    r_ext_be_n;
   logic          r_ext_wen;
   logic          w_gnt0, w_gnt1, w_gnt, w_timeout, w_done, w_rvalid;

   always_comb begin
      w_next    = r_state;
      w_gnt0    = 1'b0;
      w_gnt1    = 1'b0;
      w_done    = 1'b0;
      w_timeout = (r_cnt == CW'(TIMEOUT - 1));
      case (r_state)
         S_IDLE: begin
            if (io_bus.m0_req && (!io_bus.m1_req || !r_rr_ptr)) w_gnt0 = 1'b1;
            else if (io_bus.m1_req)                              w_gnt1 = 1'b1;
            if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            // writes complete blind; reads need the MMIO response or the timeout
            w_done = r_wen || io_bus.mmio_en_reg || w_timeout;
            if (w_done) w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_gnt    = w_gnt0 || w_gnt1;
   assign w_rvalid = (r_state == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 1'b0;
         r_owner    <= 1'b0;
         r_wen      <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_ext_addr <= '0;
         r_ext_data <= '0;
         r_ext_be_n <= '0;
         r_ext_wen  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_ext_be_n <= '0;
         r_ext_wen  <= 1'b0;
         if (w_gnt) begin
            r_owner    <= w_gnt1;
            r_rr_ptr   <= ~w_gnt1;
            r_wen      <= w_gnt1 ? io_bus.m1_wen   : io_bus.m0_wen;
            r_ext_wen  <= w_gnt1 ? io_bus.m1_wen   : io_bus.m0_wen;
            r_ext_addr <= w_gnt1 ? io_bus.m1_addr  : io_bus.m0_addr;
            r_ext_data <= w_gnt1 ? io_bus.m1_wdata : io_bus.m0_wdata;
            r_ext_be_n <= w_gnt1 ? io_bus.m1_be_n  : io_bus.m0_be_n;
         end
         if (r_state == S_ISSUE)                r_cnt <= '0;
         else if (r_state == S_WAIT && !w_done) r_cnt <= r_cnt + 1'b1;
         // response data beats a simultaneous timeout
         if (w_done) begin
            r_rdata <= (!r_wen && io_bus.mmio_en_reg) ? io_bus.mmio_read_data : '0;
            r_err   <= !r_wen && !io_bus.mmio_en_reg;
         end else if (w_rvalid) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
         end
      end
   end

   assign io_bus.m0_gnt       = w_gnt0;
   assign io_bus.m1_gnt       = w_gnt1;
   assign io_bus.m0_rvalid    = w_rvalid && !r_owner;
   assign io_bus.m1_rvalid    = w_rvalid &&  r_owner;
   assign io_bus.m0_rdata     = (w_rvalid && !r_owner) ? r_rdata : '0;
   assign io_bus.m1_rdata     = (w_rvalid &&  r_owner) ? r_rdata : '0;
   assign io_bus.m0_err       = w_rvalid && !r_owner && r_err;
   assign io_bus.m1_err       = w_rvalid &&  r_owner && r_err;
   assign io_bus.ext_addr     = r_ext_addr;
   assign io_bus.ext_data     = r_ext_data;
   assign io_bus.ext_ram_be_n = r_ext_be_n;
   assign io_bus.ext_ram_wen  = r_ext_wen;

`ifdef MMIO_ARB_STATS_EN
   logic [CNT_W-1:0] r_stat_gnt0, r_stat_gnt1, r_stat_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_gnt0    <= '0;
         r_stat_gnt1    <= '0;
         r_stat_timeout <= '0;
      end else begin
         if (w_gnt0 && r_stat_gnt0 != '1)               r_stat_gnt0    <= r_stat_gnt0 + 1'b1;
         if (w_gnt1 && r_stat_gnt1 != '1)               r_stat_gnt1    <= r_stat_gnt1 + 1'b1;
         if (w_rvalid && r_err && r_stat_timeout != '1) r_stat_timeout <= r_stat_timeout + 1'b1;
      end
   end

   assign stat_gnt0    = r_stat_gnt0;
   assign stat_gnt1    = r_stat_gnt1;
   assign stat_timeout = r_stat_timeout;
`endif
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: vector table for grant/issue/response sequencing,
// hand-written sequences for timeout, late response, zero mask, write and mid-flight reset.
module tb_mmio_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mmio_bus_arbiter_if bus();
`ifdef MMIO_ARB_STATS_EN
   logic [31:0] stat_gnt0, stat_gnt1, stat_timeout;
`endif

   mmio_bus_arbiter #(.TIMEOUT(16)) dut (
      .clk(clk),
      .rst(rst),
      .io_bus(bus)
`ifdef MMIO_ARB_STATS_EN
      , .stat_gnt0(stat_gnt0),
      .stat_gnt1(stat_gnt1),
      .stat_timeout(stat_timeout)
`endif
   );

   typedef struct {
      logic        req0, wen0; logic [31:0] a0; logic [7:0] be0;
      logic        req1, wen1; logic [31:0] a1; logic [7:0] be1;
      logic [63:0] wdata;
      logic        en;  logic [63:0] rd;
      logic        g0, g1, rv0, rv1;
      logic [63:0] erd; logic err;
      logic [7:0]  ebe; logic ewen; logic [31:0] eaddr; logic [63:0] edata;
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   task automatic txn(input string nm, input bit mst, input logic wen, input logic [31:0] addr,
                      input logic [7:0] be, input int en_at, input logic [63:0] rd,
                      input int exp_lat, input logic exp_err, input logic [63:0] exp_rd);
      int   lat;
      bit   other;
      logic rv;
      lat   = -1;
      other = 1'b0;
      if (mst) begin
         bus.m1_req = 1'b1; bus.m1_wen = wen; bus.m1_addr = addr; bus.m1_be_n = be; bus.m1_wdata = 64'h77;
      end else begin
         bus.m0_req = 1'b1; bus.m0_wen = wen; bus.m0_addr = addr; bus.m0_be_n = be; bus.m0_wdata = 64'h77;
      end
      #1;
      chk({nm, " gnt"}, mst ? bus.m1_gnt : bus.m0_gnt, 1'b1);
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         bus.m0_req = 1'b0;
         bus.m1_req = 1'b0;
         bus.mmio_en_reg    = (k == en_at);
         bus.mmio_read_data = (k == en_at) ? rd : 64'hbad0;
         #1;
         if (k == 1) begin
            chk({nm, " ext_be"},   bus.ext_ram_be_n, be);
            chk({nm, " ext_addr"}, bus.ext_addr, addr);
            chk({nm, " ext_wen"},  bus.ext_ram_wen, wen);
         end
         if (mst ? bus.m0_rvalid : bus.m1_rvalid) other = 1'b1;
         rv = mst ? bus.m1_rvalid : bus.m0_rvalid;
         if (rv) begin
            lat = k;
            chk({nm, " rdata"}, mst ? bus.m1_rdata : bus.m0_rdata, exp_rd);
            chk({nm, " err"},   mst ? bus.m1_err   : bus.m0_err,   exp_err);
         end
      end
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, " other rvalid"}, other, 1'b0);
      @(posedge clk); #1;
      bus.mmio_en_reg = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // read / write / contended round-robin, one line per clock
      vt[0]  = '{1,0,32'ha0000100,8'h0F, 0,0,0,0, 0, 0,0, 1,0,0,0, 0,0, 8'h00,0, 32'h0,         0};
      vt[1]  = '{0,0,32'ha0000100,8'h0F, 0,0,0,0, 0, 0,0, 0,0,0,0, 0,0, 8'h0F,0, 32'ha0000100, 0};
      vt[2]  = '{0,0,32'ha0000100,8'h0F, 0,0,0,0, 0, 1,64'h012c0190, 0,0,0,0, 0,0, 8'h00,0, 32'ha0000100, 0};
      vt[3]  = '{0,0,0,0, 0,0,0,0, 0, 0,0, 0,0,1,0, 64'h012c0190,0, 8'h00,0, 32'ha0000100, 0};
      vt[4]  = '{0,0,0,0, 1,1,32'ha00003f8,8'h01, 64'h41, 0,0, 0,1,0,0, 0,0, 8'h00,0, 32'ha0000100, 0};
      vt[5]  = '{0,0,0,0, 0,1,32'ha00003f8,8'h01, 64'h41, 0,0, 0,0,0,0, 0,0, 8'h01,1, 32'ha00003f8, 64'h41};
      vt[6]  = '{0,0,0,0, 0,1,32'ha00003f8,8'h01, 64'h41, 1,64'hdead, 0,0,0,0, 0,0, 8'h00,0, 32'ha00003f8, 64'h41};
      vt[7]  = '{0,0,0,0, 0,0,0,0, 64'h41, 0,0, 0,0,0,1, 0,0, 8'h00,0, 32'ha00003f8, 64'h41};
      vt[8]  = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 1,0,0,0, 0,0, 8'h00,0, 32'ha00003f8, 64'h41};
      vt[9]  = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 0,0,0,0, 0,0, 8'hFF,0, 32'ha0000020, 0};
      vt[10] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 1,64'h1, 0,0,0,0, 0,0, 8'h00,0, 32'ha0000020, 0};
      vt[11] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 0,0,1,0, 64'h1,0, 8'h00,0, 32'ha0000020, 0};
      vt[12] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 0,1,0,0, 0,0, 8'h00,0, 32'ha0000020, 0};
      vt[13] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 1,64'h99, 0,0,0,0, 0,0, 8'h3C,0, 32'ha0000030, 0};
      vt[14] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 1,64'h2, 0,0,0,0, 0,0, 8'h00,0, 32'ha0000030, 0};
      vt[15] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 0,0,0,1, 64'h2,0, 8'h00,0, 32'ha0000030, 0};
      vt[16] = '{1,0,32'ha0000020,8'hFF, 1,0,32'ha0000030,8'h3C, 0, 0,0, 1,0,0,0, 0,0, 8'h00,0, 32'ha0000030, 0};
      vt[17] = '{0,0,32'ha0000020,8'hFF, 0,0,32'ha0000030,8'h3C, 0, 0,0, 0,0,0,0, 0,0, 8'hFF,0, 32'ha0000020, 0};
      vt[18] = '{0,0,32'ha0000020,8'hFF, 0,0,32'ha0000030,8'h3C, 0, 1,64'h3, 0,0,0,0, 0,0, 8'h00,0, 32'ha0000020, 0};
      vt[19] = '{0,0,0,0, 0,0,0,0, 0, 0,0, 0,0,1,0, 64'h3,0, 8'h00,0, 32'ha0000020, 0};

      rst = 1'b1;
      bus.m0_req = 0; bus.m0_wen = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be_n = '0;
      bus.m1_req = 0; bus.m1_wen = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be_n = '0;
      bus.mmio_en_reg = 0; bus.mmio_read_data = '0;
      #12;
      chk("reset m0_gnt",    bus.m0_gnt, 0);
      chk("reset m1_gnt",    bus.m1_gnt, 0);
      chk("reset m0_rvalid", bus.m0_rvalid, 0);
      chk("reset m1_rvalid", bus.m1_rvalid, 0);
      chk("reset m0_rdata",  bus.m0_rdata, 0);
      chk("reset m1_rdata",  bus.m1_rdata, 0);
      chk("reset m0_err",    bus.m0_err, 0);
      chk("reset m1_err",    bus.m1_err, 0);
      chk("reset ext_addr",  bus.ext_addr, 0);
      chk("reset ext_data",  bus.ext_data, 0);
      chk("reset ext_be",    bus.ext_ram_be_n, 0);
      chk("reset ext_wen",   bus.ext_ram_wen, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         bus.m0_req = vt[i].req0; bus.m0_wen = vt[i].wen0; bus.m0_addr = vt[i].a0;
         bus.m0_be_n = vt[i].be0; bus.m0_wdata = vt[i].wdata;
         bus.m1_req = vt[i].req1; bus.m1_wen = vt[i].wen1; bus.m1_addr = vt[i].a1;
         bus.m1_be_n = vt[i].be1; bus.m1_wdata = vt[i].wdata;
         bus.mmio_en_reg = vt[i].en; bus.mmio_read_data = vt[i].rd;
         #1;
         chk($sformatf("v%0d m0_gnt", i),    bus.m0_gnt, vt[i].g0);
         chk($sformatf("v%0d m1_gnt", i),    bus.m1_gnt, vt[i].g1);
         chk($sformatf("v%0d m0_rvalid", i), bus.m0_rvalid, vt[i].rv0);
         chk($sformatf("v%0d m1_rvalid", i), bus.m1_rvalid, vt[i].rv1);
         chk($sformatf("v%0d m0_rdata", i),  bus.m0_rdata, vt[i].rv0 ? vt[i].erd : 64'h0);
         chk($sformatf("v%0d m1_rdata", i),  bus.m1_rdata, vt[i].rv1 ? vt[i].erd : 64'h0);
         chk($sformatf("v%0d m0_err", i),    bus.m0_err, vt[i].rv0 & vt[i].err);
         chk($sformatf("v%0d m1_err", i),    bus.m1_err, vt[i].rv1 & vt[i].err);
         chk($sformatf("v%0d ext_be", i),    bus.ext_ram_be_n, vt[i].ebe);
         chk($sformatf("v%0d ext_wen", i),   bus.ext_ram_wen, vt[i].ewen);
         chk($sformatf("v%0d ext_addr", i),  bus.ext_addr, vt[i].eaddr);
         chk($sformatf("v%0d ext_data", i),  bus.ext_data, vt[i].edata);
         @(posedge clk); #1;
      end
      bus.mmio_en_reg = 1'b0;

      txn("unmapped timeout", 1'b0, 1'b0, 32'hb0000000, 8'hFF, 0,  64'h0,    18, 1'b1, 64'h0);
      txn("late response",    1'b1, 1'b0, 32'ha0000200, 8'hFF, 17, 64'h5a5a, 18, 1'b0, 64'h5a5a);
      txn("zero mask read",   1'b0, 1'b0, 32'ha0000100, 8'h00, 0,  64'h0,    18, 1'b1, 64'h0);
      txn("m0 write",         1'b0, 1'b1, 32'ha0000008, 8'hF0, 0,  64'h0,    3,  1'b0, 64'h0);
`ifdef MMIO_ARB_STATS_EN
      chk("stat_gnt0",    stat_gnt0, 6);
      chk("stat_gnt1",    stat_gnt1, 3);
      chk("stat_timeout", stat_timeout, 2);
`endif

      // reset while an m0 read waits for its response
      bus.m0_req = 1'b1; bus.m0_wen = 1'b0; bus.m0_addr = 32'ha0000048; bus.m0_be_n = 8'hFF;
      #1;
      chk("rst-seq gnt0", bus.m0_gnt, 1);
      @(posedge clk); #1;
      bus.m0_req = 1'b0;
      #1;
      chk("rst-seq issue addr", bus.ext_addr, 32'ha0000048);
      @(posedge clk); #1;
      #2;
      rst = 1'b1;
      #1;
      chk("rst-seq ext_addr", bus.ext_addr, 0);
      chk("rst-seq ext_data", bus.ext_data, 0);
      chk("rst-seq ext_be",   bus.ext_ram_be_n, 0);
      chk("rst-seq ext_wen",  bus.ext_ram_wen, 0);
      chk("rst-seq m0_rvalid", bus.m0_rvalid, 0);
      chk("rst-seq m0_err",   bus.m0_err, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst-seq hold m0_rvalid", bus.m0_rvalid, 0);
      end
      rst = 1'b0;
`ifdef MMIO_ARB_STATS_EN
      chk("rst-seq stat_gnt0", stat_gnt0, 0);
`endif
      txn("post-reset m1", 1'b1, 1'b0, 32'ha0000300, 8'h0F, 2, 64'h1234, 3, 1'b0, 64'h1234);
`ifdef MMIO_ARB_STATS_EN
      chk("post-reset stat_gnt1", stat_gnt1, 1);
      chk("post-reset stat_timeout", stat_timeout, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
